// File: rtl/seq_stream_ctrl.sv
// Stimulus sequencer / hit scoreboard for single-bit serial sequence detectors.
// Latency: din/busy valid one cycle after start accept; done rises seq_len+DRAIN+1 cycles after accept.
// Backpressure: none; start is honoured only in IDLE (not while busy or while done shows), otherwise dropped.
//
// Ports:
//   clk, rst (sync, active-low)  | start, seq_word, seq_len : command
//   det : detector output scored | din : serial bit to detector
//   busy, done, err : status     | hit_cnt : saturating hit counter
//   first_hit : busy-cycle index of first hit (only with SEQ_STREAM_CTRL_HITLOG_EN)
//
// Optional feature macro: SEQ_STREAM_CTRL_HITLOG_EN
module seq_stream_ctrl #(
  parameter int SEQ_W = 32,
  parameter int LEN_W = 6,
  parameter int CNT_W = 8,
  parameter int DRAIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEQ_W-1:0] seq_word,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             det,
  output logic             din,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef SEQ_STREAM_CTRL_HITLOG_EN
  output logic [LEN_W+3:0] first_hit,
`endif
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [SEQ_W-1:0] shreg;
  logic [LEN_W-1:0] bit_cnt;
  logic [DCW-1:0]   drain_cnt;
  logic             len_ok;
  logic             accept;
  logic             reject;
  logic             din_n;
  logic             busy_n;
  logic             done_n;

  assign len_ok = (seq_len != '0) && (seq_len <= LEN_W'(SEQ_W));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are registered one cycle behind the state, so the visible done
  // cycle coincides with state IDLE; gating on done keeps start ignored there.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    din_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !done) begin
          if (len_ok) begin
            accept  = 1'b1;
            state_n = S_RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_RUN: begin
        din_n  = shreg[SEQ_W-1];
        busy_n = 1'b1;
        if (bit_cnt == LEN_W'(1)) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        busy_n = 1'b1;
        if (drain_cnt == '0) state_n = S_DONE;
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      din       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      drain_cnt <= '0;
      hit_cnt   <= '0;
    end else begin
      din  <= din_n;
      busy <= busy_n;
      done <= done_n;
      err  <= reject;

      if (accept) begin
        // Left-justify the pattern so the first bit streamed is seq_word[seq_len-1]
        shreg   <= seq_word << (LEN_W'(SEQ_W) - seq_len);
        bit_cnt <= seq_len;
      end else if (state == S_RUN) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt - LEN_W'(1);
      end

      if (state == S_RUN) begin
        drain_cnt <= DCW'(DRAIN - 1);
      end else if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt - DCW'(1);
      end

      if (accept) begin
        hit_cnt <= '0;
      end else if (busy && det && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_STREAM_CTRL_HITLOG_EN
  logic [LEN_W+3:0] busy_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_idx  <= '0;
      first_hit <= '1;
    end else if (accept) begin
      busy_idx  <= '0;
      first_hit <= '1;
    end else if (busy) begin
      busy_idx <= busy_idx + 1'b1;
      if (det && (first_hit == '1)) first_hit <= busy_idx;
    end
  end
`endif

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Randomized self-checking bench for seq_stream_ctrl against a cycle-indexed reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_seq_stream_ctrl;

  localparam int SEQ_W = 32;
  localparam int LEN_W = 6;
  localparam int DRAIN = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [SEQ_W-1:0] seq_word;
  logic [LEN_W-1:0] seq_len;
  logic             det;
  logic             det_r;
  logic             loopback;
  logic             din;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       hit_cnt;
  logic             din2;
  logic             busy2;
  logic             done2;
  logic             err2;
  logic [3:0]       hit_cnt2;

  int checks;
  int failures;
  int last_hits;

  assign det = loopback ? din : det_r;

  seq_stream_ctrl #(.SEQ_W(SEQ_W), .LEN_W(LEN_W), .CNT_W(8), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_word(seq_word), .seq_len(seq_len),
    .det(det), .din(din), .busy(busy), .done(done), .err(err), .hit_cnt(hit_cnt)
  );

  // Narrow counter with det stuck high to exercise saturation
  seq_stream_ctrl #(.SEQ_W(SEQ_W), .LEN_W(LEN_W), .CNT_W(4), .DRAIN(DRAIN)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .seq_word(seq_word), .seq_len(seq_len),
    .det(1'b1), .din(din2), .busy(busy2), .done(done2), .err(err2), .hit_cnt(hit_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Streams one legal command. Cycle k counts negedges after the accepting edge.
  task automatic run_one(input logic [31:0] w, input int len, input bit loop, input bit poke);
    int   exp_hits;
    int   hold_hits;
    logic exp_din;
    logic exp_busy;
    logic det_now;
    exp_hits = 0;
    hold_hits = 0;
    @(negedge clk);
    seq_word = w;
    seq_len  = LEN_W'(len);
    start    = 1'b1;
    loopback = loop;
    det_r    = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    seq_word = $urandom;
    seq_len  = LEN_W'($urandom_range(0, 40));
    det_r    = 1'($urandom);
    check("busy_k0", 32'(busy), 32'd0);
    for (int k = 1; k <= len + DRAIN + 2; k++) begin
      @(negedge clk);
      exp_busy = (k <= len + DRAIN);
      exp_din  = (k <= len) ? w[len-k] : 1'b0;
      check("din", 32'(din), 32'(exp_din));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(k == len + DRAIN + 1));
      check("err", 32'(err), 32'd0);
      if (k == len + DRAIN + 1) begin
        hold_hits = (exp_hits > 255) ? 255 : exp_hits;
        check("hit_cnt", 32'(hit_cnt), 32'(hold_hits));
        check("hit_sat", 32'(hit_cnt2), 32'((len + DRAIN > 15) ? 15 : len + DRAIN));
      end
      if (k == len + DRAIN + 2) check("hit_hold", 32'(hit_cnt), 32'(hold_hits));
      det_r   = 1'($urandom);
      det_now = loop ? exp_din : det_r;
      if (exp_busy && det_now) exp_hits++;
      start = poke && (k == 3 || k == len + DRAIN + 1);
    end
    start = 1'b0;
    last_hits = hold_hits;
  endtask

  task automatic bad_len(input int len);
    @(negedge clk);
    seq_len = LEN_W'(len);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_hits", 32'(hit_cnt), 32'(last_hits));
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    check("err_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] pat;
    checks    = 0;
    failures  = 0;
    last_hits = 0;
    rst       = 1'b0;
    start     = 1'b1;
    seq_word  = 32'hFFFF_FFFF;
    seq_len   = 6'd8;
    det_r     = 1'b1;
    loopback  = 1'b0;

    // Reset held with start asserted
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_din", 32'(din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_hits", 32'(hit_cnt), 32'd0);
    end
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    // Loopback with the reference 21-bit pattern; 9 ones in it
    pat = 32'b001100101100010011010;
    run_one(pat, 21, 1'b1, 1'b1);
    check("pattern_hits", 32'(last_hits), 32'd9);

    // Illegal lengths
    bad_len(0);
    bad_len(SEQ_W + 1);

    // Boundaries
    run_one(32'h1, 1, 1'b1, 1'b0);
    run_one(32'hDEAD_BEEF, 20, 1'b0, 1'b1);
    run_one($urandom, SEQ_W, 1'b1, 1'b1);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      run_one($urandom, $urandom_range(1, SEQ_W), 1'($urandom), 1'($urandom));
    end

    // Abort mid-run at bit 10
    @(negedge clk);
    seq_word = 32'hFFFF_FFFF;
    seq_len  = 6'd20;
    loopback = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("abort_din", 32'(din), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_din0", 32'(din), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hits", 32'(hit_cnt), 32'd0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    last_hits = 0;
    run_one(32'h0005_A5A5, 17, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
